// File: rtl/i2s_rx_deframer.sv
// I2S receive deframer: recovers MSB-first words from sd/ws in the sclk domain
// and hands them out over a valid/ready port with channel tag and error flags.
package i2s_rx_deframer_pkg;
    typedef enum logic {F16BITS = 1'b0, F32BITS = 1'b1} frame_size_e;
    typedef struct packed {
        frame_size_e frame_size;
        logic        mute;
        logic        stop;
    } op_t;
endpackage

module i2s_rx_deframer
    import i2s_rx_deframer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ws_i,
    input  logic             sd_i,
    input  op_t              op_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             dout_ch_o,
    output logic             dout_valid_o,
    input  logic             dout_ready_i,
    output logic             locked_o,
    output logic             overrun_o,
    output logic             frame_err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

    state_e             state_q, state_d;
    logic               ws_q, armed_q;
    logic [4:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               n16_q, n16_d;
    logic               ch_q, ch_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               dout_ch_q, dout_ch_d;
    logic               dout_valid_q, dout_valid_d;
    logic               overrun_q, overrun_d;
    logic               frame_err_q;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               edge_det, complete, ferr, start, accept;
    logic [4:0]         last_bit;
    logic [WIDTH-1:0]   word;

    // ws_q tracks ws even while unarmed so the first post-reset cycle cannot fake an edge
    assign edge_det = armed_q && (ws_i != ws_q);
    assign last_bit = n16_q ? 5'd15 : 5'd31;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        n16_d    = n16_q;
        ch_d     = ch_q;
        complete = 1'b0;
        ferr     = 1'b0;
        start    = 1'b0;
        if (op_i.stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q == last_bit) begin
                        complete = 1'b1;
                        state_d  = HOLD;
                        start    = edge_det;
                    end else if (edge_det) begin
                        ferr  = 1'b1;
                        start = 1'b1;
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], sd_i};
                        cnt_d   = cnt_q + 5'd1;
                    end
                end
                default: start = edge_det;
            endcase
            if (start) begin
                state_d = SHIFT;
                cnt_d   = '0;
                shreg_d = '0;
                n16_d   = (op_i.frame_size == F16BITS);
                ch_d    = ws_i;
            end
        end
    end

    always_comb begin
        word = {shreg_q[WIDTH-2:0], sd_i};
        if (n16_q)
            word[WIDTH-1:16] = '0;
        if (op_i.mute)
            word = '0;
    end

    always_comb begin
        accept       = !dout_valid_q || dout_ready_i;
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q && !dout_ready_i;
        if (complete && accept) begin
            dout_d       = word;
            dout_ch_d    = ch_q;
            dout_valid_d = 1'b1;
        end
        overrun_d = complete && !accept;
        err_cnt_d = (ferr && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            ws_q         <= 1'b0;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            shreg_q      <= '0;
            n16_q        <= 1'b0;
            ch_q         <= 1'b0;
            dout_q       <= '0;
            dout_ch_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ws_q         <= ws_i;
            armed_q      <= 1'b1;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            n16_q        <= n16_d;
            ch_q         <= ch_d;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= ferr;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_ch_o    = dout_ch_q;
    assign dout_valid_o = dout_valid_q;
    assign locked_o     = (state_q != IDLE);
    assign overrun_o    = overrun_q;
    assign frame_err_o  = frame_err_q;
    assign err_cnt_o    = err_cnt_q;

endmodule
